// File: rtl/clk_mon_scan_pkg.sv
// Shared types and sizing helpers for the round-robin clock-monitor scanner.
package clk_mon_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        WAIT,
        NEXT
    } state_t;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_mon_next_chan.sv
// Finds the lowest set bit of mask strictly above idx; idx is two's complement,
// so idx = -1 returns the lowest set bit of the whole mask.
module clk_mon_next_chan #(
    parameter int NCLK  = 16,
    parameter int SEL_W = $clog2(NCLK)
) (
    input  logic [NCLK-1:0]  mask,
    input  logic [SEL_W:0]   idx,
    output logic             found,
    output logic [SEL_W-1:0] next_idx
);

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        // Descending walk so the last hit, i.e. the lowest qualifying bit, wins.
        for (int i = NCLK - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'($signed(idx)))) begin
                found    = 1'b1;
                next_idx = i[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/clk_mon_scan_ctrl.sv
// Round-robin scheduler sharing one frequency-measurement engine across NCLK
// clocks: select, settle, gate, collect, write result, advance.
module clk_mon_scan_ctrl
    import clk_mon_scan_pkg::*;
#(
    parameter int NCLK           = 16,
    parameter int SEL_W          = $clog2(NCLK),
    parameter int CNT_W          = 32,
    parameter int SETTLE_CYCLES  = 16,
    parameter int GATE_CYCLES    = 100000,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_ref,
    input  logic             reset_in,
    input  logic             start,
    input  logic             run,
    input  logic             abort,
    input  logic [NCLK-1:0]  en_mask,
    output logic [SEL_W-1:0] meas_sel,
    output logic             meas_clr,
    output logic             meas_gate,
    input  logic [CNT_W-1:0] meas_count,
    input  logic             meas_valid,
    output logic             result_we,
    output logic [SEL_W-1:0] result_idx,
    output logic [CNT_W-1:0] result_data,
    output logic [NCLK-1:0]  timeout_mask,
    output logic             busy,
    output logic             scan_done,
    output logic [31:0]      scan_count
);

    localparam int PH_MAX = (SETTLE_CYCLES > GATE_CYCLES)
        ? ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES)
        : ((GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES);
    localparam int PH_W = cnt_width(PH_MAX);

    localparam logic [PH_W-1:0] SETTLE_LOAD  = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] GATE_LOAD    = PH_W'(GATE_CYCLES - 1);
    localparam logic [PH_W-1:0] TIMEOUT_LOAD = PH_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [NCLK-1:0]   mask_q;
    logic [SEL_W-1:0]  chan;
    logic [PH_W-1:0]   ph_cnt;

    logic              nxt_found;
    logic [SEL_W-1:0]  nxt_idx;
    logic              first_found;
    logic [SEL_W-1:0]  first_idx;

    // Next channel of the latched mask above the one just measured.
    clk_mon_next_chan #(.NCLK(NCLK), .SEL_W(SEL_W)) u_next (
        .mask     (mask_q),
        .idx      ({1'b0, chan}),
        .found    (nxt_found),
        .next_idx (nxt_idx)
    );

    // Lowest enabled channel of the live mask, used at every scan start.
    clk_mon_next_chan #(.NCLK(NCLK), .SEL_W(SEL_W)) u_first (
        .mask     (en_mask),
        .idx      ({(SEL_W + 1){1'b1}}),
        .found    (first_found),
        .next_idx (first_idx)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk_ref) begin
        if (reset_in) begin
            state        <= IDLE;
            mask_q       <= '0;
            chan         <= '0;
            ph_cnt       <= '0;
            meas_sel     <= '0;
            meas_clr     <= 1'b0;
            meas_gate    <= 1'b0;
            result_we    <= 1'b0;
            result_idx   <= '0;
            result_data  <= '0;
            timeout_mask <= '0;
            scan_done    <= 1'b0;
            scan_count   <= '0;
        end else begin
            result_we <= 1'b0;
            scan_done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                meas_gate <= 1'b0;
                meas_clr  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if ((start || run) && first_found) begin
                            mask_q   <= en_mask;
                            chan     <= first_idx;
                            meas_sel <= first_idx;
                            meas_clr <= 1'b1;
                            ph_cnt   <= SETTLE_LOAD;
                            state    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (ph_cnt == '0) begin
                            meas_clr  <= 1'b0;
                            meas_gate <= 1'b1;
                            ph_cnt    <= GATE_LOAD;
                            state     <= GATE;
                        end else begin
                            ph_cnt <= ph_cnt - PH_W'(1);
                        end
                    end
                    GATE: begin
                        if (ph_cnt == '0) begin
                            meas_gate <= 1'b0;
                            ph_cnt    <= TIMEOUT_LOAD;
                            state     <= WAIT;
                        end else begin
                            ph_cnt <= ph_cnt - PH_W'(1);
                        end
                    end
                    WAIT: begin
                        // A valid arriving on the final timeout cycle still wins.
                        if (meas_valid) begin
                            result_we          <= 1'b1;
                            result_idx         <= chan;
                            result_data        <= meas_count;
                            timeout_mask[chan] <= 1'b0;
                            state              <= NEXT;
                        end else if (ph_cnt == '0) begin
                            result_we          <= 1'b1;
                            result_idx         <= chan;
                            result_data        <= '0;
                            timeout_mask[chan] <= 1'b1;
                            state              <= NEXT;
                        end else begin
                            ph_cnt <= ph_cnt - PH_W'(1);
                        end
                    end
                    NEXT: begin
                        if (nxt_found) begin
                            chan     <= nxt_idx;
                            meas_sel <= nxt_idx;
                            meas_clr <= 1'b1;
                            ph_cnt   <= SETTLE_LOAD;
                            state    <= SETTLE;
                        end else begin
                            scan_done  <= 1'b1;
                            scan_count <= scan_count + 32'd1;
                            if (run && first_found) begin
                                mask_q   <= en_mask;
                                chan     <= first_idx;
                                meas_sel <= first_idx;
                                meas_clr <= 1'b1;
                                ph_cnt   <= SETTLE_LOAD;
                                state    <= SETTLE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/clk_mon_scan_ctrl.md
Name: clk_mon_scan_ctrl

Overview:
Round-robin scheduler that shares one frequency-measurement engine across NCLK monitored clocks, all in the clk_ref domain.
- Selects a channel on the engine's clock mux, clears the engine and lets the mux settle.
- Opens a fixed gate window, collects the synchronized count and writes it to the per-channel result registers.
- Replaces per-channel rate counters in large clock-monitor instances; software sees the same rate/timeout view per channel.

Parameters:
NCLK, 16, number of monitored clocks (2..64)
SEL_W, $clog2(NCLK), mux select width
CNT_W, 32, count/result width
SETTLE_CYCLES, 16, clk_ref cycles spent in SETTLE after a mux change (>=1)
GATE_CYCLES, 100000, clk_ref cycles the gate is held high (>=1)
TIMEOUT_CYCLES, 1024, clk_ref cycles allowed for meas_valid after the gate closes (>=1)

Ports:
clk_ref  in  1  only clock
reset_in  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: run one scan
run  in  1  level: scan continuously
abort  in  1  one-cycle pulse: stop immediately, no result write
en_mask  in  NCLK  channels to scan; latched at scan start
meas_sel  out  SEL_W  clock-mux select to the engine
meas_clr  out  1  engine counter clear
meas_gate  out  1  engine count-enable window
meas_count  in  CNT_W  engine result, clk_ref domain
meas_valid  in  1  one-cycle pulse: meas_count is valid
result_we  out  1  one-cycle result write strobe
result_idx  out  SEL_W  channel being written
result_data  out  CNT_W  count, or 0 on timeout
timeout_mask  out  NCLK  sticky per-channel timeout flags
busy  out  1  high whenever the state is not IDLE
scan_done  out  1  one-cycle pulse at the end of every scan
scan_count  out  32  completed scans, wraps at 2^32

Behaviour:
Reset values:
- All outputs 0, state IDLE, channel 0.

State machine:
- IDLE: start or run with (en_mask != 0) → latch en_mask into mask_q; chan = lowest set bit; go to SETTLE next cycle.
  - start or run with en_mask == 0 → stay in IDLE, no scan_done.
- SETTLE: meas_sel = chan (held until the channel changes); meas_clr = 1.
  - Down-counter loaded with SETTLE_CYCLES-1; leave on count 0, so exactly SETTLE_CYCLES cycles → GATE.
- GATE: meas_gate = 1 for exactly GATE_CYCLES cycles; meas_clr = 0 → WAIT.
- WAIT: meas_gate = 0; timeout counter runs.
  - meas_valid → result_we = 1 next cycle with result_data = meas_count, result_idx = chan; clear timeout_mask[chan].
  - No meas_valid within TIMEOUT_CYCLES cycles → result_we with result_data = 0; set timeout_mask[chan].
  - meas_valid and the timeout landing on the same cycle → valid wins.
  - meas_valid outside WAIT is ignored.
- NEXT (1 cycle, coincides with the result_we cycle): find the next set bit of mask_q above chan.
  - Found → SETTLE on that channel.
  - Not found → scan_done = 1 and scan_count++. Then, if run is high, re-latch en_mask and restart at its lowest set bit (IDLE rules apply if it is 0); otherwise go to IDLE.
- run deasserting mid-scan: the current scan completes, no new one starts.
- start while busy: ignored.

Abort and reset:
- abort (any non-IDLE state): IDLE next cycle; meas_gate, meas_clr and result_we forced to 0; no scan_done, no scan_count change; timeout_mask preserved.
- abort in IDLE: no effect.
- reset_in has priority over abort and start and returns everything to reset values on the next edge, mid-scan included.

Timing and width rules:
- Per-channel cost = SETTLE_CYCLES + GATE_CYCLES + WAIT cycles + 1.
- Counters sized $clog2(max+1); no saturation logic needed on meas_count.

Decomposition:
- Package clk_mon_scan_pkg: state enum (IDLE, SETTLE, GATE, WAIT, NEXT) and the width helper function.
- Sub-module clk_mon_next_chan: combinational "next set bit above index" finder (mask, current index → found, next index), reused for lowest-bit search with index = -1.

Test Plan:
All scenarios use NCLK=4, SETTLE=4, GATE=10, TIMEOUT=8.
- start with en_mask=4'b1011, engine returns 100/200/300 three cycles after each gate → result_we idx 0, 1, 3 with data 100, 200, 300; meas_gate high exactly 10 cycles per channel; one scan_done; scan_count=1.
- en_mask=4'b0100, engine never returns meas_valid → result_we idx 2, data 0, 8 cycles after gate close; timeout_mask=4'b0100; next scan with valid=55 clears it.
- run held high for 3 scans with en_mask=4'b0001 → scan_count=3, busy stays high between scans; run dropped mid-GATE → scan completes, then IDLE.
- abort pulsed during GATE of channel 1 → meas_gate=0 next cycle, no result_we, no scan_done; IDLE.
- reset_in during WAIT → all outputs 0 next cycle, including timeout_mask and scan_count; start with en_mask=0 → busy stays 0.
- meas_valid on the same cycle the timeout expires → data written, timeout flag clear; a stray meas_valid in IDLE → no write.
